// File: rtl/bank_mem_responder_if.sv
// Request/response bus of the banked memory responder.
// The master drives the request; the slave answers with stall/err
// in the same cycle and with read data two cycles after acceptance.
interface bank_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, stall, busy, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, stall, busy, err
    );
endinterface

// File: rtl/bank_mem_responder.sv
// Four-bank 16-bit memory responder.
// addr[2:1] picks the bank and addr[15:3] the word inside it. A bank
// stays occupied for four cycles after it accepts a request, so requests
// to other banks can be interleaved one per cycle. Reads return after a
// fixed two-cycle latency; data_out is zero in every other cycle.
module bank_mem_responder (
    input  logic                 clk,
    input  logic                 rst,
    bank_mem_responder_if.slave  bus
);
    localparam int DATA_W   = 16;
    localparam int BANKS    = 4;
    localparam int DEPTH    = 8192;
    localparam int IDX_W    = 13;
    localparam logic [2:0] OCC_LOAD = 3'd4;

    logic              req;
    logic              err_c;
    logic              stall_c;
    logic              accept;
    logic [1:0]        bank;
    logic [IDX_W-1:0]  idx;
    logic [BANKS-1:0]  busy_c;
    logic [2:0]        occ_cnt [BANKS];

    logic [DATA_W-1:0] mem [BANKS][DEPTH];

    logic              vld_p1;
    logic [1:0]        bank_p1;
    logic [IDX_W-1:0]  idx_p1;
    logic [DATA_W-1:0] data_p2;

    assign bank = bus.addr[2:1];
    assign idx  = bus.addr[15:3];

    // Request decode: an illegal request is flagged as err and never as stall.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            busy_c[b] = (occ_cnt[b] != 3'd0);
        end
        req     = bus.rd | bus.wr;
        err_c   = req & (bus.addr[0] | (bus.rd & bus.wr));
        stall_c = req & ~err_c & busy_c[bank];
        accept  = req & ~err_c & ~stall_c;
    end

    // Per-bank occupancy: load on acceptance, then count down to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin
                occ_cnt[b] <= 3'd0;
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (accept && (bank == b[1:0])) begin
                    occ_cnt[b] <= OCC_LOAD;
                end else if (occ_cnt[b] != 3'd0) begin
                    occ_cnt[b] <= occ_cnt[b] - 3'd1;
                end
            end
        end
    end

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            mem[bank][idx] <= bus.data_in;
        end
    end

    // ---- stage 1: capture accepted read (valid flag is reset, address is not)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept & bus.rd;
        end
    end

    // Stage-1 read address, only meaningful while vld_p1 is set.
    always_ff @(posedge clk) begin
        if (accept && bus.rd) begin
            bank_p1 <= bank;
            idx_p1  <= idx;
        end
    end

    // ---- stage 2: read return, zero whenever no read is completing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p2 <= '0;
        end else if (vld_p1) begin
            data_p2 <= mem[bank_p1][idx_p1];
        end else begin
            data_p2 <= '0;
        end
    end

    assign bus.data_out = data_p2;
    assign bus.stall    = stall_c;
    assign bus.err      = err_c;
    assign bus.busy     = busy_c;
endmodule

// File: tb/tb_bank_mem_responder.sv
// Self-checking bench for bank_mem_responder. Expected read data is pushed
// to a scoreboard queue when a read is issued and popped when it returns.
module tb_bank_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    bank_mem_responder_if bus_if ();

    bank_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus_if.rd      = r;
        bus_if.wr      = w;
        bus_if.addr    = a;
        bus_if.data_in = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int n);
        idle();
        repeat (n) next_cycle();
    endtask

    // Single read with scoreboard check, then wait until its bank is free again.
    task automatic do_read(input logic [15:0] a, input logic [15:0] expd, input string name);
        drive(1'b1, 1'b0, a, 16'h0000);
        @(negedge clk);
        n_vec++;
        if (bus_if.stall !== 1'b0 || bus_if.err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_accept: stall=%b err=%b, required 0/0", name, bus_if.stall, bus_if.err);
        end
        exp_q.push_back(expd);
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (bus_if.data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL %s_early: data_out=%h, required 0000", name, bus_if.data_out);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_sb: scoreboard empty, data_out=%h", name, bus_if.data_out);
        end else begin
            exp_v = exp_q.pop_front();
            if (bus_if.data_out !== exp_v) begin
                n_bad++;
                $display("FAIL %s_data: data_out=%h, required %h", name, bus_if.data_out, exp_v);
            end
        end
        next_cycle();
        repeat (2) next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus_if.busy !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_busy: got %b, required 0000", bus_if.busy);
        end
        n_vec++;
        if (bus_if.data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data: got %h, required 0000", bus_if.data_out);
        end
        n_vec++;
        if (bus_if.stall !== 1'b0 || bus_if.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall_err: got %b/%b, required 0/0", bus_if.stall, bus_if.err);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (bus_if.busy !== 4'b0000 || bus_if.data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy=%b data_out=%h, required 0000/0000", bus_if.busy, bus_if.data_out);
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        // cycle 0: write BEEF to bank 0
        drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        @(negedge clk);
        n_vec++;
        if (bus_if.stall !== 1'b0 || bus_if.err !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_accept: stall=%b err=%b, required 0/0", bus_if.stall, bus_if.err);
        end
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) drive(1'b1, 1'b0, 16'h0010, 16'h0000);
            else idle();
            @(negedge clk);
            n_vec++;
            if (bus_if.busy !== 4'b0001) begin
                n_bad++;
                $display("FAIL wr_busy_c%0d: got %b, required 0001", c, bus_if.busy);
            end
            n_vec++;
            if (bus_if.stall !== (c == 2)) begin
                n_bad++;
                $display("FAIL wr_stall_c%0d: got %b, required %b", c, bus_if.stall, (c == 2));
            end
            next_cycle();
        end
        // cycle 5: bank free, read accepted
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        n_vec++;
        if (bus_if.busy !== 4'b0000 || bus_if.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_c5: busy=%b stall=%b, required 0000/0", bus_if.busy, bus_if.stall);
        end
        exp_q.push_back(16'hBEEF);
        next_cycle();
        idle();
        for (int c = 6; c <= 8; c++) begin
            @(negedge clk);
            n_vec++;
            if (c == 7) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_sb: scoreboard empty, data_out=%h", bus_if.data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (bus_if.data_out !== exp_v) begin
                        n_bad++;
                        $display("FAIL rd_data_c7: got %h, required %h", bus_if.data_out, exp_v);
                    end
                end
            end else if (bus_if.data_out !== 16'h0000) begin
                n_bad++;
                $display("FAIL rd_zero_c%0d: got %h, required 0000", c, bus_if.data_out);
            end
            next_cycle();
        end
        wait_idle(3);
    endtask

    task automatic test_back_to_back();
        logic [15:0] wdat [4];
        logic [3:0]  bexp [4];
        logic [15:0] a;
        wdat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        bexp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int k = 0; k < 4; k++) begin
            a = 16'h0100 + 16'(2 * k);
            drive(1'b0, 1'b1, a, wdat[k]);
            next_cycle();
        end
        wait_idle(5);
        for (int k = 0; k <= 6; k++) begin
            if (k < 4) begin
                a = 16'h0100 + 16'(2 * k);
                drive(1'b1, 1'b0, a, 16'h0000);
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 4) begin
                n_vec++;
                if (bus_if.stall !== 1'b0 || bus_if.err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_accept_%0d: stall=%b err=%b, required 0/0", k, bus_if.stall, bus_if.err);
                end
                exp_q.push_back(wdat[k]);
            end
            if (k >= 1 && k <= 4) begin
                n_vec++;
                if (bus_if.busy !== bexp[k-1]) begin
                    n_bad++;
                    $display("FAIL b2b_busy_%0d: got %b, required %b", k, bus_if.busy, bexp[k-1]);
                end
            end
            n_vec++;
            if (k >= 2 && k <= 5) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_sb_%0d: scoreboard empty, data_out=%h", k, bus_if.data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (bus_if.data_out !== exp_v) begin
                        n_bad++;
                        $display("FAIL b2b_data_%0d: got %h, required %h", k, bus_if.data_out, exp_v);
                    end
                end
            end else if (bus_if.data_out !== 16'h0000) begin
                n_bad++;
                $display("FAIL b2b_zero_%0d: got %h, required 0000", k, bus_if.data_out);
            end
            next_cycle();
        end
        wait_idle(3);
    endtask

    task automatic test_errors();
        drive(1'b0, 1'b1, 16'h0020, 16'h5A5A);
        next_cycle();
        // odd address while bank 0 is busy: err wins over stall
        drive(1'b1, 1'b0, 16'h0011, 16'h0000);
        @(negedge clk);
        n_vec++;
        if (bus_if.err !== 1'b1 || bus_if.stall !== 1'b0 || bus_if.busy !== 4'b0001) begin
            n_bad++;
            $display("FAIL err_odd: err=%b stall=%b busy=%b, required 1/0/0001", bus_if.err, bus_if.stall, bus_if.busy);
        end
        next_cycle();
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus_if.data_out !== 16'h0000) begin
                n_bad++;
                $display("FAIL err_odd_nodata_%0d: got %h, required 0000", c, bus_if.data_out);
            end
            next_cycle();
        end
        wait_idle(2);
        // rd and wr together with an idle bank
        drive(1'b1, 1'b1, 16'h0020, 16'hDEAD);
        @(negedge clk);
        n_vec++;
        if (bus_if.err !== 1'b1 || bus_if.stall !== 1'b0) begin
            n_bad++;
            $display("FAIL err_rdwr: err=%b stall=%b, required 1/0", bus_if.err, bus_if.stall);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++;
        if (bus_if.busy !== 4'b0000) begin
            n_bad++;
            $display("FAIL err_rdwr_busy: got %b, required 0000", bus_if.busy);
        end
        n_vec++;
        if (bus_if.err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_idle: got %b, required 0", bus_if.err);
        end
        next_cycle();
        do_read(16'h0020, 16'h5A5A, "err_storage");
    endtask

    task automatic test_stall_hold();
        drive(1'b0, 1'b1, 16'h0002, 16'h0A0A);
        next_cycle();
        drive(1'b0, 1'b1, 16'h000A, 16'h7777);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus_if.stall !== 1'b1 || bus_if.busy[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_stall_c%0d: stall=%b busy1=%b, required 1/1", c, bus_if.stall, bus_if.busy[1]);
            end
            next_cycle();
        end
        @(negedge clk);
        n_vec++;
        if (bus_if.stall !== 1'b0 || bus_if.busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_accept: stall=%b busy1=%b, required 0/0", bus_if.stall, bus_if.busy[1]);
        end
        next_cycle();
        idle();
        for (int c = 6; c <= 10; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus_if.busy[1] !== (c <= 9)) begin
                n_bad++;
                $display("FAIL hold_busy_c%0d: got %b, required %b", c, bus_if.busy[1], (c <= 9));
            end
            next_cycle();
        end
        do_read(16'h000A, 16'h7777, "hold_new");
        do_read(16'h0002, 16'h0A0A, "hold_old");
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        next_cycle();
        idle();
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (bus_if.busy !== 4'b0000 || bus_if.data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL rst_mid_immediate: busy=%b data_out=%h, required 0000/0000", bus_if.busy, bus_if.data_out);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus_if.busy !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_mid_busy: got %b, required 0000", bus_if.busy);
        end
        next_cycle();
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus_if.data_out !== 16'h0000 || bus_if.busy !== 4'b0000) begin
                n_bad++;
                $display("FAIL rst_mid_quiet_c%0d: data_out=%h busy=%b, required 0000/0000", c, bus_if.data_out, bus_if.busy);
            end
            next_cycle();
        end
        do_read(16'h0010, 16'hBEEF, "rst_persist");
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_errors();
        test_stall_hold();
        test_reset_mid_read();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d entries, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bank_mem_responder.md
BANK_MEM_RESPONDER -- requirements
Module: bank_mem_responder

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous reset, active high.
REQ-004 addr  input  16  byte address of the request; addr[2:1] selects the bank, addr[15:3] selects the word within the bank.
REQ-005 data_in  input  16  write data.
REQ-006 rd  input  1  read request.
REQ-007 wr  input  1  write request.
REQ-008 data_out  output  16  read data; nonzero only in the return cycle.
REQ-009 stall  output  1  combinational; the request this cycle is refused.
REQ-010 busy  output  4  busy[b] is high while bank b is occupied.
REQ-011 err  output  1  combinational; the request this cycle is illegal.

Function
REQ-012 Storage SHALL be 4 banks, each 8192 x 16 bits.
REQ-013 A request SHALL be present when rd|wr is high.
REQ-014 err SHALL be 1 when a request is present and either addr[0]=1 or rd&wr=1; otherwise err SHALL be 0.
REQ-015 stall SHALL be 1 when a request is present, err=0, and busy[addr[2:1]]=1; otherwise stall SHALL be 0.
REQ-016 A request SHALL be accepted at the rising edge ending cycle 0 only if it is present, err=0 and stall=0.
REQ-017 A refused request (stall or err) SHALL cause no change to storage, busy or the read pipeline.
REQ-018 Each bank SHALL have a 3-bit occupancy counter.
  - Acceptance loads the counter with 4.
  - A nonzero counter decrements each cycle.
  - busy[b] = (counter_b != 0).
  - busy[b] is therefore high for exactly cycles 1..4 after acceptance, and bank b can accept again in cycle 5.
REQ-019 An accepted write SHALL update bank[addr[2:1]][addr[15:3]] with data_in at the acceptance edge.
REQ-020 An accepted read SHALL register its bank and index into stage 1 at the acceptance edge.
REQ-021 At the next edge, stage 1 SHALL load data_out with the addressed word.
  - data_out is valid during cycle 2 only.
  - Fixed read latency is 2 cycles.
REQ-022 In any cycle without a valid read return, data_out SHALL be 16'h0000.
REQ-023 Requests to different banks SHALL be acceptable in consecutive cycles, with at most one new request per cycle.
  - Read returns emerge in acceptance order, one per cycle, with no collision.
REQ-024 A write to bank b SHALL NOT alter data already captured by an in-flight read.
REQ-025 A read of a word after its write SHALL return the written value, because the bank is busy until the write is complete.
REQ-026 The occupancy counters of all four banks SHALL operate independently and concurrently.

Reset
REQ-027 On rst=1, regardless of clock, the block SHALL immediately clear:
  - all occupancy counters, so busy=4'b0000;
  - the stage-1 valid flag;
  - data_out, to 16'h0000.
REQ-028 stall and err SHALL follow their combinational definitions during reset, with busy forced to 0.
REQ-029 Storage contents SHALL NOT be cleared by reset; writes accepted before reset SHALL persist.
REQ-030 A read in flight when rst asserts SHALL be discarded, and no data_out pulse SHALL follow after reset is released.

Verification
REQ-031 Write then read, same bank:
  - Cycle 0: wr, addr=16'h0010, data_in=16'hBEEF -> busy=4'b0001 for cycles 1-4.
  - rd to 16'h0010 in cycle 2 -> stall=1.
  - rd in cycle 5 -> accepted, data_out=16'hBEEF in cycle 7, 0 in cycles 6 and 8.
REQ-032 Bank interleave:
  - Prior writes of 16'h1111, 2222, 3333, 4444 to addrs 16'h0100, 0102, 0104, 0106.
  - Reads to those addrs issued in consecutive cycles c..c+3 -> all accepted, no stall.
  - data_out = 16'h1111, 2222, 3333, 4444 in cycles c+2..c+5.
  - busy shows 0001, 0011, 0111, 1111 in cycles c+1..c+4.
REQ-033 Errors:
  - rd with addr=16'h0011 -> err=1, stall=0, busy unchanged, no data_out.
  - rd=wr=1 with addr=16'h0020 -> err=1, storage unchanged.
REQ-034 Stall hold: wr held on bank 1 while busy[1]=1 -> stall=1 every busy cycle; the write is accepted in the first cycle busy[1]=0, and storage is updated once.
REQ-035 Reset mid-read:
  - Accept rd at 16'h0010 in cycle 0, then pulse rst in cycle 1.
  - -> busy=0 and data_out=0 immediately, with no data_out pulse afterward.
  - A later read of 16'h0010 returns the pre-reset value 16'hBEEF.
REQ-036 Reset value check: after rst from power-up -> busy=4'b0000, data_out=16'h0000; stall=0 and err=0 with no request present.
